// File: rtl/adc_wave_capture_if.sv
// Sample stream, arm/trigger controls and buffer-RAM write port
// for the ADC waveform capture block.
interface adc_wave_capture_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] adc_data;
  logic                  adc_valid;
  logic                  arm;
  logic [DATA_WIDTH-1:0] trig_level;
  logic                  trig_edge;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  busy;
  logic                  done;
  logic                  auto_trig;

  modport master (
    output adc_data,
    output adc_valid,
    output arm,
    output trig_level,
    output trig_edge,
    input  ram_wr_en,
    input  ram_wr_addr,
    input  ram_wr_data,
    input  busy,
    input  done,
    input  auto_trig
  );

  modport slave (
    input  adc_data,
    input  adc_valid,
    input  arm,
    input  trig_level,
    input  trig_edge,
    output ram_wr_en,
    output ram_wr_addr,
    output ram_wr_data,
    output busy,
    output done,
    output auto_trig
  );

endinterface

// File: rtl/adc_wave_capture.sv
// Edge/timeout triggered ADC waveform capture into an external RAM.
// The trigger sample lands at address 0; one pass fills the buffer.
module adc_wave_capture #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic clk,
  input  logic rst,
  adc_wave_capture_if.slave bus
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] level_q, level_d;
  logic                  falling_q, falling_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  prev_vld_q, prev_vld_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  auto_q, auto_d;
  logic [ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic arm_ok;
  logic smp_armed;
  logic rise_hit;
  logic fall_hit;
  logic edge_hit;
  logic edge_trig;
  logic to_trig;
  logic trig;
  logic full;
  logic smp_cap;

  always_comb begin
    arm_ok = bus.arm &&
      (state_q == S_IDLE || state_q == S_DONE);
    smp_armed = bus.adc_valid && state_q == S_ARMED;
    rise_hit = (prev_q < level_q) &&
      (bus.adc_data >= level_q);
    fall_hit = (prev_q > level_q) &&
      (bus.adc_data <= level_q);
    edge_hit = falling_q ? fall_hit : rise_hit;
    edge_trig = smp_armed && prev_vld_q && edge_hit;
    // Edge wins over timeout on the same sample.
    to_trig = smp_armed && prev_vld_q && !edge_hit &&
      TO_EN && (to_cnt_q == TO_LAST);
    trig = edge_trig || to_trig;
    full = wr_cnt_q[ADDR_WIDTH];
    smp_cap = bus.adc_valid && state_q == S_CAPTURE && !full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      arm_ok: state_d = S_ARMED;
      trig: state_d = S_CAPTURE;
      full && state_q == S_CAPTURE: state_d = S_DONE;
      default: ;
    endcase
  end

  always_comb begin
    bus.busy = state_q == S_ARMED || state_q == S_CAPTURE;
    bus.done = state_q == S_DONE;
    bus.auto_trig = auto_q;
    bus.ram_wr_en = wr_en_q;
    bus.ram_wr_addr = wr_addr_q;
    bus.ram_wr_data = wr_data_q;
  end

  always_comb begin
    level_d = level_q;
    falling_d = falling_q;
    prev_d = prev_q;
    prev_vld_d = prev_vld_q;
    to_cnt_d = to_cnt_q;
    auto_d = auto_q;
    wr_cnt_d = wr_cnt_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (arm_ok) begin
      level_d = bus.trig_level;
      falling_d = bus.trig_edge;
      prev_vld_d = 1'b0;
      to_cnt_d = '0;
      auto_d = 1'b0;
      wr_cnt_d = '0;
    end

    if (smp_armed) begin
      to_cnt_d = to_cnt_q + 1'b1;
      prev_d = bus.adc_data;
      prev_vld_d = 1'b1;
    end

    if (trig) begin
      auto_d = to_trig;
      wr_en_d = 1'b1;
      wr_addr_d = '0;
      wr_data_d = bus.adc_data;
      wr_cnt_d = {{ADDR_WIDTH{1'b0}}, 1'b1};
    end

    // Counter MSB marks a full buffer, so no wrap.
    if (smp_cap) begin
      wr_en_d = 1'b1;
      wr_addr_d = wr_cnt_q[ADDR_WIDTH-1:0];
      wr_data_d = bus.adc_data;
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      falling_q <= 1'b0;
      prev_q <= '0;
      prev_vld_q <= 1'b0;
      to_cnt_q <= '0;
      auto_q <= 1'b0;
      wr_cnt_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      level_q <= level_d;
      falling_q <= falling_d;
      prev_q <= prev_d;
      prev_vld_q <= prev_vld_d;
      to_cnt_q <= to_cnt_d;
      auto_q <= auto_d;
      wr_cnt_q <= wr_cnt_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_adc_wave_capture.sv
// Randomized scoreboard bench for adc_wave_capture: a sample-level
// capture model predicts each cycle's outputs, a monitor compares.
module tb_adc_wave_capture;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TIMEOUT = 8;
  localparam int DEPTH = 2 ** AW;

  localparam int P_IDLE = 0;
  localparam int P_ARMED = 1;
  localparam int P_CAP = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE = 4;

  typedef struct {
    bit busy;
    bit done;
    bit auto_t;
    bit wr;
    bit zb;
    int addr;
    int data;
  } exp_t;

  logic clk;
  logic rst;

  adc_wave_capture_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  adc_wave_capture #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int obs = 0;

  int m_ph = P_IDLE;
  int m_lvl;
  bit m_fall;
  int m_prev;
  bit m_has_prev;
  int m_n;
  int m_idx;
  bit m_auto;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish (cycles=%0d)", obs);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d",
        nm, obs, act, want);
    end
  endtask

  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #2;
      obs++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("busy", int'(bus.busy), int'(e.busy));
        chk("done", int'(bus.done), int'(e.done));
        chk("auto_trig", int'(bus.auto_trig), int'(e.auto_t));
        chk("ram_wr_en", int'(bus.ram_wr_en), int'(e.wr));
        if (e.wr || e.zb) begin
          chk("ram_wr_addr", int'(bus.ram_wr_addr), e.addr);
          chk("ram_wr_data", int'(bus.ram_wr_data), e.data);
        end
      end
    end
  end

  // One clock of stimulus; the model predicts what the registered
  // outputs must show right after this edge.
  task automatic step(input bit r, input bit a, input bit v,
                      input int d);
    exp_t e;
    bit hit;
    bit tmo;
    bit wr_now;
    rst = r;
    bus.arm = a;
    bus.adc_valid = v;
    bus.adc_data = DW'(d);
    e = '{default: 0};
    wr_now = 0;
    if (r) begin
      m_ph = P_IDLE;
      m_auto = 0;
      m_has_prev = 0;
      m_n = 0;
      e.zb = 1;
    end else begin
      case (m_ph)
        P_DRAIN: m_ph = P_DONE;
        P_IDLE, P_DONE: begin
          if (a) begin
            m_lvl = int'(bus.trig_level);
            m_fall = bus.trig_edge;
            m_auto = 0;
            m_has_prev = 0;
            m_n = 0;
            m_ph = P_ARMED;
          end
        end
        P_ARMED: begin
          if (v) begin
            m_n++;
            if (!m_has_prev) begin
              m_prev = d;
              m_has_prev = 1;
            end else begin
              hit = m_fall ? (m_prev > m_lvl && d <= m_lvl)
                           : (m_prev < m_lvl && d >= m_lvl);
              tmo = (TIMEOUT != 0) && (m_n == TIMEOUT);
              if (hit || tmo) begin
                m_auto = !hit;
                m_idx = 0;
                m_ph = P_CAP;
                wr_now = 1;
              end else begin
                m_prev = d;
              end
            end
          end
        end
        P_CAP: if (v) wr_now = 1;
        default: ;
      endcase
      if (wr_now) begin
        e.wr = 1;
        e.addr = m_idx;
        e.data = d;
        m_idx++;
        if (m_idx == DEPTH) m_ph = P_DRAIN;
      end
    end
    e.busy = (m_ph == P_ARMED || m_ph == P_CAP || m_ph == P_DRAIN);
    e.done = (m_ph == P_DONE);
    e.auto_t = m_auto;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cap(input int lvl, input bit fe);
    bus.trig_level = DW'(lvl);
    bus.trig_edge = fe;
    step(0, 1, 0, 0);
  endtask

  task automatic finish_cap(input int per);
    for (int i = 0; i < 300 && m_ph != P_DONE; i++)
      step(0, 0, (i % per) == 0, $urandom_range(0, 255));
    step(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.adc_data = '0;
    bus.adc_valid = 1'b0;
    bus.arm = 1'b0;
    bus.trig_level = '0;
    bus.trig_edge = 1'b0;

    repeat (3) step(1, 0, 0, 0);
    step(0, 0, 1, 9);

    // rising ramp through level 128
    arm_cap(128, 0);
    for (int i = 0; i < 40 && m_ph != P_DONE; i++)
      step(0, 0, 1, (100 + 20 * i > 255) ? 255 : 100 + 20 * i);
    step(0, 0, 0, 0);
    step(0, 0, 1, 3);

    // falling through 128, re-armed from DONE
    arm_cap(128, 1);
    step(0, 0, 1, 200);
    step(0, 0, 1, 150);
    step(0, 0, 1, 128);
    step(0, 0, 1, 90);
    finish_cap(1);

    // flat input: timeout on the 8th sample
    arm_cap(128, 0);
    for (int i = 0; i < 30 && m_ph != P_DONE; i++)
      step(0, 0, 1, 50);
    finish_cap(1);

    // edge on the 8th sample beats the timeout
    arm_cap(128, 0);
    repeat (7) step(0, 0, 1, 10);
    step(0, 0, 1, 200);
    finish_cap(1);

    // sparse valid during capture
    arm_cap(128, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 255);
    finish_cap(3);

    // arm ignored mid-capture, then reset after the 5th write
    arm_cap(128, 0);
    step(0, 0, 1, 100);
    step(0, 0, 1, 200);
    step(0, 0, 1, 11);
    step(0, 1, 1, 22);
    step(0, 0, 1, 33);
    step(0, 0, 1, 44);
    step(0, 0, 0, 0);
    step(1, 0, 1, 77);
    repeat (10) step(0, 0, 1, $urandom_range(0, 255));

    // re-arm from DONE with level 0 and a first sample of 255
    arm_cap(128, 1);
    step(0, 0, 1, 255);
    step(0, 0, 1, 0);
    finish_cap(2);
    arm_cap(0, 0);
    step(0, 0, 1, 255);
    finish_cap(1);

    for (int ep = 0; ep < 8; ep++) begin
      arm_cap($urandom_range(0, 255), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 150 && m_ph != P_DONE && m_ph != P_IDLE; i++)
        step($urandom_range(0, 199) == 0,
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 255));
      step(0, 0, 0, 0);
    end

    step(0, 0, 0, 0);
    #10;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
